// File: rtl/gpio_link_pkg.sv
// Constants shared by the GPO transmitter and the GPI receiver of the parallel link.
package gpio_link_pkg;

    // Width of the parallel data bus between transmitter and receiver.
    localparam int unsigned DATA_W = 23;

    // INTR is an active-low strobe and idles high.
    localparam logic INTR_ACTIVE = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Pointers carry one extra wrap bit, so full and empty come
// straight from the pointers and no occupancy counter is needed.
module sync_fifo #(
    parameter int unsigned DATA_W = 23,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_en;
    logic              rd_en;

    // Flags and handshake qualification.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_en   = pop_i && !empty_o;
        // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
        wr_en   = push_i && (!full_o || rd_en);
        rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next-state for pointers and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data_i;
            wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
        end
    end

    // State registers; storage is cleared so the head reads 0 after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/gpi_receiver.sv
// Receiver for the parallel GPI link: synchronises INTR and GPI, captures one word
// per INTR falling edge, buffers words in a FIFO and streams them out valid/ready.
// Words arriving while the FIFO is full (and not being popped) set a sticky overflow.
module gpi_receiver #(
    parameter int unsigned DATA_W      = gpio_link_pkg::DATA_W,
    parameter int unsigned SYNC_STAGES = 2,   // legal range 1..3
    parameter int unsigned DEPTH       = 4,   // power of two, >= 2
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] GPI,
    input  logic              INTR,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    input  logic              clr_overflow,
    output logic [CNT_W-1:0]  word_count
);

    import gpio_link_pkg::*;

    logic [SYNC_STAGES-1:0] intr_sync_q, intr_sync_d;
    logic [DATA_W-1:0]      gpi_sync_q [SYNC_STAGES];
    logic [DATA_W-1:0]      gpi_sync_d [SYNC_STAGES];
    logic                   intr_prev_q, intr_prev_d;
    logic                   overflow_q, overflow_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   intr_sync;
    logic [DATA_W-1:0]      gpi_sync;
    logic                   strobe;
    logic                   pop;
    logic                   push_ok;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Shift INTR and GPI through the synchroniser together so data stays aligned
    // with the strobe that qualifies it.
    always_comb begin
        intr_sync_d    = intr_sync_q;
        gpi_sync_d     = gpi_sync_q;
        intr_sync_d[0] = INTR;
        gpi_sync_d[0]  = GPI;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            intr_sync_d[i] = intr_sync_q[i-1];
            gpi_sync_d[i]  = gpi_sync_q[i-1];
        end
    end

    // Falling-edge detect on the synchronised strobe and FIFO handshake decode.
    always_comb begin
        intr_sync   = intr_sync_q[SYNC_STAGES-1];
        gpi_sync    = gpi_sync_q[SYNC_STAGES-1];
        intr_prev_d = intr_sync;
        strobe      = (intr_sync == INTR_ACTIVE) && (intr_prev_q != INTR_ACTIVE);
        out_valid   = !fifo_empty;
        pop         = out_valid && out_ready;
        push_ok     = strobe && (!fifo_full || pop);
        drop        = strobe && fifo_full && !pop;
    end

    // Sticky overflow (a new drop beats a clear) and wrapping accepted-word counter.
    always_comb begin
        overflow_d = overflow_q;
        count_d    = count_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
        if (push_ok) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // State registers; INTR history resets to idle so release causes no false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            intr_sync_q <= '1;
            intr_prev_q <= ~INTR_ACTIVE;
            overflow_q  <= 1'b0;
            count_q     <= '0;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                gpi_sync_q[i] <= '0;
            end
        end else begin
            intr_sync_q <= intr_sync_d;
            gpi_sync_q  <= gpi_sync_d;
            intr_prev_q <= intr_prev_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
        end
    end

    assign overflow   = overflow_q;
    assign word_count = count_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (reset),
        .push_i    (strobe),
        .wr_data_i (gpi_sync),
        .pop_i     (pop),
        .rd_data_o (out_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

endmodule
